// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
// Raster timing generator and pixel sequencer for the three TMDS encoders.
// It counts h/v position, pulls pixels from a show-ahead source and presents
// display enable, {vsync,hsync} and RGB data one clock after the request stage.
// Optional build macro: TEST_PATTERN_EN adds internal 8-bar colour pattern.
`timescale 1ns/1ps

module hdmi_video_timing_ctrl #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        pi_clk,
   input  logic        pi_rst,
   input  logic        pi_enable,
   input  logic [23:0] pi_pix_data,
   input  logic        pi_pix_valid,
   input  logic        pi_underflow_clr,
   input  logic        pi_pattern_sel,
   output logic        po_pix_req,
   output logic        po_frame_start,
   output logic        po_display_en,
   output logic [1:0]  po_control,
   output logic [7:0]  po_data_r,
   output logic [7:0]  po_data_g,
   output logic [7:0]  po_data_b,
   output logic        po_underflow
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W      = $clog2(H_TOTAL);
   localparam int V_W      = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t         state, state_nxt;
   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;
   logic           running, frame_end, active, req;
   logic           hs_region, vs_region, pattern_on;
   logic [23:0]    bar_rgb, pix_q;

   assign running   = (state != ST_IDLE);
   assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign active    = running && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign hs_region = running && (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
   assign vs_region = running && (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

`ifdef TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [2:0] bar_idx;

   // Bar index from horizontal position; bars are BAR_W pixels wide.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (int'(h_cnt) >= i * BAR_W) bar_idx = 3'(i);
      end
   end

   // Bar order white..black: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
   assign bar_rgb    = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
   assign pattern_on = pi_pattern_sel;
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = pi_pattern_sel;
   assign bar_rgb    = '0;
   assign pattern_on = 1'b0;
`endif

   // Request stage: the pattern generator replaces the upstream source entirely.
   assign req            = active && !pattern_on;
   assign po_pix_req     = req;
   assign po_frame_start = running && (h_cnt == '0) && (v_cnt == '0);

   // State register.
   always_ff @(posedge pi_clk or posedge pi_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (pi_rst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state: stopping is only allowed at the last pixel of a frame.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (pi_enable) state_nxt = ST_RUN;
         ST_RUN:   if (!pi_enable) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: begin
            if (pi_enable)      state_nxt = ST_RUN;
            else if (frame_end) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Raster counters: held at zero while idle so every start is a fresh frame.
   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst || state == ST_IDLE) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Output stage: everything the encoders see is registered one clock after the request.
   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst) begin
         po_display_en <= 1'b0;
         po_control    <= {~VS_POL, ~HS_POL};
         pix_q         <= '0;
      end else begin
         po_display_en <= active;
         po_control    <= {vs_region ? VS_POL : ~VS_POL, hs_region ? HS_POL : ~HS_POL};
         if (active && pattern_on)    pix_q <= bar_rgb;
         else if (req && pi_pix_valid) pix_q <= pi_pix_data;
         else                          pix_q <= '0;
      end
   end

   // Sticky underflow: a missing pixel sets it, and a set beats a same-cycle clear.
   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst)                      po_underflow <= 1'b0;
      else if (req && !pi_pix_valid)   po_underflow <= 1'b1;
      else if (pi_underflow_clr)       po_underflow <= 1'b0;
   end

   assign po_data_r = pix_q[23:16];
   assign po_data_g = pix_q[15:8];
   assign po_data_b = pix_q[7:0];

endmodule
